// File: rtl/fetch_queue.sv
// Instruction-fetch stage: sequential PC, on-chip instruction memory and a
// small {pc, word} prefetch queue feeding decode over valid/ready.
module fetch_queue #(
   parameter int                ADDR_W    = 8,
   parameter int                WORD_W    = 17,
   parameter int                MEM_DEPTH = 64,
   parameter int                Q_DEPTH   = 4,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
   input  logic                       rst,
   input  logic                       clk,
   input  logic                       redirect,
   input  logic [ADDR_W-1:0]          redirect_pc,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [ADDR_W+WORD_W-1:0]   out_inst,
   input  logic                       mem_we,
   input  logic [ADDR_W-1:0]          mem_waddr,
   input  logic [WORD_W-1:0]          mem_wdata,
   output logic [$clog2(Q_DEPTH):0]   q_count
);

   localparam int IDX_W = $clog2(MEM_DEPTH);
   localparam int PTR_W = $clog2(Q_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] Q_FULL = CNT_W'(Q_DEPTH);

   logic [WORD_W-1:0] mem_q      [MEM_DEPTH];
   logic [ADDR_W-1:0] ent_pc_q   [Q_DEPTH];
   logic [WORD_W-1:0] ent_word_q [Q_DEPTH];

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              pop, push;

   // Redirect hides the (stale) head combinationally so decode never takes it.
   assign out_valid = (count_q != '0) & ~redirect;
   assign out_inst  = out_valid ? {ent_pc_q[head_q], ent_word_q[head_q]} : '0;
   assign q_count   = count_q;
   assign pop       = out_valid & out_ready;
   assign push      = ~redirect & ((count_q != Q_FULL) | pop);

   // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
   always_comb begin
      pc_d    = pc_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (redirect) begin
         pc_d    = redirect_pc;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push) begin
            pc_d   = pc_q + ADDR_W'(1);
            tail_d = tail_q + PTR_W'(1);
         end
         if (pop) head_d = head_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // NOTE: state flops use non-blocking assignments so every flop sees pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q    <= RESET_PC;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         pc_q    <= pc_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // NOTE: storage arrays carry no reset; validity lives in count_q, and contents survive reset.
   // The entry capture reads mem_q before this edge's write lands, so it sees the old word.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[mem_waddr[IDX_W-1:0]] <= mem_wdata;
      if (push) begin
         ent_pc_q[tail_q]   <= pc_q;
         ent_word_q[tail_q] <= mem_q[pc_q[IDX_W-1:0]];
      end
   end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction-fetch stage with an internal PC, instruction memory and a prefetch queue.
- Reads sequentially from on-chip instruction memory into a small FIFO of {pc, word} entries.
- Hands entries to decode over a valid/ready handshake.
- Branch/jump redirect flushes the queue and restarts fetch at a new PC.
- Sits between the PC/branch logic and the decode stage; replaces the single-register fetch stage.

Parameters:
- ADDR_W, 8: PC width in bits.
- WORD_W, 17: instruction word width in bits.
- MEM_DEPTH, 64: instruction memory entries; power of two, ≤ 2^ADDR_W.
- Q_DEPTH, 4: prefetch queue entries; power of two, ≥ 2.
- RESET_PC, 0: PC value after reset.

Ports:
- rst  in  1  asynchronous, active-low reset
- clk  in  1  clock; all state updates on posedge clk
- redirect  in  1  branch or jump taken (do_branch | do_jump)
- redirect_pc  in  ADDR_W  fetch restart address
- out_valid  out  1  queue head holds a valid instruction
- out_ready  in  1  decode accepts head this cycle
- out_inst  out  ADDR_W+WORD_W  {pc, word} of head; all zero when out_valid=0
- mem_we  in  1  instruction-memory write enable (program load)
- mem_waddr  in  ADDR_W  write address; low log2(MEM_DEPTH) bits used
- mem_wdata  in  WORD_W  write data
- q_count  out  log2(Q_DEPTH)+1  current number of queue entries

Behaviour:
- Reset (rst=0, async):
  - queue emptied: q_count=0, out_valid=0, out_inst=0.
  - fetch PC <= RESET_PC.
  - memory contents not reset.
  - Reset mid-operation discards all queued entries.
- Memory indexing:
  - Index = pc[log2(MEM_DEPTH)-1:0]; addresses alias modulo MEM_DEPTH.
  - Write is synchronous on mem_we.
  - Same-edge write and fetch to the same index: the fetch captures the OLD word.
- Definitions:
  - pop = out_valid & out_ready & !redirect.
  - push allowed when redirect=0 and (q_count < Q_DEPTH or pop=1).
- On an edge with push:
  - Tail entry <= {pc, memory[pc index]}.
  - pc <= pc + 1, wrapping modulo 2^ADDR_W (0xFF -> 0x00 at ADDR_W=8).
- No push (queue full, no pop): pc holds and the memory read is not performed.
- Latency:
  - A word fetched at edge E is visible on out_inst after E, so the queue is never bypassed combinationally.
  - Steady state with out_ready=1: one instruction per cycle, no bubbles.
- Handshake:
  - out_inst/out_valid change only at clock edges, or combinationally via redirect.
  - Head is held stable while out_valid=1 and out_ready=0.
- Redirect (sampled at edge E):
  - Queue cleared; q_count=0 after E.
  - pc <= redirect_pc; no push or pop at E.
  - While redirect=1, out_valid is forced 0 combinationally and out_inst=0.
  - First redirected entry is pushed at E+1 and visible after E+1.
  - Redirect overrides simultaneous pop and push; redirect on consecutive cycles: the last one wins.
- Simultaneous push and pop:
  - At full: allowed, q_count unchanged.
  - At empty: impossible, since pop needs out_valid.
- Queue implementation:
  - Circular buffer with head/tail pointers of log2(Q_DEPTH) bits that wrap naturally.
  - Full/empty distinguished by q_count.

Test Plan:
- Reset release with mem[0..3]=0x00011,0x00022,0x00033,0x00044, out_ready=1:
  - out_valid rises after the first edge.
  - out_inst sequence {0x00,0x00011}, {0x01,0x00022}, {0x02,0x00033}, one per cycle.
- out_ready=0 for 10 cycles:
  - q_count saturates at 4, pc stops at 4, head stays {0x00,0x00011}.
  - Then out_ready=1 streams pc 0..7 with no gap.
- Redirect to 0x20 with queue holding 3 entries, out_ready=1:
  - out_valid=0 during the redirect cycle; q_count=0 next.
  - Next accepted entry has pc=0x20; no stale pc 1..3 entries are ever accepted.
- PC wrap: redirect_pc=0xFE, MEM_DEPTH=64:
  - Entries pc=0xFE, 0xFF, 0x00 with words mem[62], mem[63], mem[0].
- mem_we to index 5 in the same edge as the fetch of pc=5:
  - Fetched word is the old value; after redirect to 5 the new value is fetched.
- Assert rst=0 asynchronously mid-stream with q_count=3:
  - out_valid=0 and q_count=0 immediately.
  - After release the first entry has pc=RESET_PC.
